fetch_ctrl: RTL
===============

// Module: fetch_ctrl
// PURPOSE
//  Sequences instruction fetch for the RV32 core: owns the fetch PC, issues one-outstanding
//  requests to instruction memory and hands instructions to decode over a valid/ready link.
//  Arbitrates PC redirect sources: trap > branch/jump > sequential +4.
//  Sits between the imem port and the decode stage; replaces free-running PC increment.
// PARAMETERS
//  RESET_VEC  32'h0000_0000  PC of first fetch after reset
//  XLEN       32             address/instruction width (only 32 supported)
// PORTS
//  clk           in   1     clock, all state on posedge
//  rst           in   1     reset, asynchronous, active-high
//  redir_valid   in   1     branch/jump taken this cycle (from EX)
//  redir_addr    in   32    branch/jump target
//  trap_valid    in   1     exception/interrupt redirect
//  trap_addr     in   32    trap vector (mtvec)
//  imem_req      out  1     fetch request valid
//  imem_addr     out  32    fetch address, stable while imem_req && !imem_ack
//  imem_ack      in   1     one-cycle response strobe; imem_rdata valid same cycle
//  imem_rdata    in   32    fetched instruction
//  inst_valid    out  1     instruction available to decode
//  inst_ready    in   1     decode accepts (transfer = inst_valid && inst_ready)
//  inst_data     out  32    instruction
//  inst_pc       out  32    PC of inst_data
//  fetch_pc      out  32    current fetch PC (debug/trace)
//  misalign_exc  out  1     see CONFIGURATION (tied 0 when feature absent)
// BEHAVIOUR
//  Reset: state=IDLE, fetch_pc=RESET_VEC, imem_req=0, inst_valid=0, inst_data=0, inst_pc=0,
//   misalign_exc=0. rst mid-request: abandon request, late imem_ack after reset ignored.
//  States: IDLE -> REQ (first cycle after reset release).
//   REQ:   imem_req=1, imem_addr=fetch_pc. On imem_ack: load inst buffer, inst_valid=1,
//          fetch_pc+=4; if buffer will be free next cycle stay REQ, else -> HOLD.
//   HOLD:  imem_req=0, inst_valid=1 until inst_ready; on transfer -> REQ.
//   FLUSH: request outstanding but redirected; imem_req stays 1 with OLD addr until imem_ack,
//          data discarded (inst_valid stays 0), then -> REQ at new fetch_pc.
//  Buffer: single entry; inst_valid drops the cycle after transfer unless a new ack lands
//   same cycle (ack + transfer simultaneous -> buffer reloaded, inst_valid stays 1).
//  Redirect (trap_valid or redir_valid), any state: fetch_pc <= trap_addr if trap_valid
//   else redir_addr; inst buffer invalidated next cycle; if REQ and no imem_ack this cycle
//   -> FLUSH; if imem_ack same cycle -> data dropped, -> REQ.
//  Both redirects same cycle: trap wins. Redirect in FLUSH: update fetch_pc, stay FLUSH.
//  Latency: redirect in cycle N -> imem_req with new addr at N+1 (no outstanding) or ack+1.
//  fetch_pc wraps 32'hFFFF_FFFC + 4 -> 0, no flag.
//  Ack outside REQ/FLUSH is ignored.
// CONFIGURATION
//  FETCH_MISALIGN_CHK_EN defined: redirect target with addr[1:0]!=0 is not fetched;
//   misalign_exc pulses 1 cycle after redirect, state -> IDLE-wait until trap_valid redirects.
//   Trap targets are not checked.
//  Undefined: addr[1:0] forced to 2'b00 on load, misalign_exc tied 0.
// STRUCTURE
//  Shared pkg/header core_defs: fetch state encoding (IDLE,REQ,HOLD,FLUSH), RESET_VEC, PC_INC=4.
//  One natural sub-module: fetch_buf (single-entry valid/ready skid holding inst_data/inst_pc).
// TESTING
//  Reset release, imem_ack 1 cycle after each req, inst_ready=1 -> inst_pc 0,4,8,... one per 2 clks.
//  inst_ready=0 for 5 cycles after first ack -> HOLD, imem_req=0, inst_data/pc stable, resume at 4.
//  redir_valid addr 0x100 while req to 0x8 outstanding, ack 3 cycles later -> data dropped, next imem_addr=0x100.
//  trap_valid(0x200)+redir_valid(0x100) same cycle -> next imem_addr=0x200, no inst from old path.
//  Ack and inst_ready same cycle in steady state -> inst_valid stays 1, no lost/duplicate inst.
//  FETCH_MISALIGN_CHK_EN: redir_addr 0x102 -> misalign_exc=1, no imem_req until trap_valid(0x300).

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared fetch definitions: state encoding, reset vector default, PC step, buffer entry type.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_ctrl_pkg;

    localparam int          XLEN_DEF      = 32;
    localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
    localparam logic [31:0] PC_INC        = 32'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FLUSH = 2'd3
    } fetch_state_e;

    // One fetched instruction together with the address it came from.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] dat;
    } inst_ent_t;

    // Instruction addresses are always word aligned.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_ctrl_buf.sv
// Single-entry instruction buffer between the imem response and decode.
// Latency: load visible on out_vld the cycle after in_vld.
// Backpressure: holds the entry while !out_rdy; a load in the transfer cycle reloads it.
//
// Ports: clk/rst; in_vld/in_dat load strobe and entry; flush drops the entry;
//        out_vld/out_rdy/out_dat valid-ready link to decode.
module fetch_ctrl_buf
    import fetch_ctrl_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      in_vld,
    input  inst_ent_t in_dat,
    input  logic      flush,
    output logic      out_vld,
    input  logic      out_rdy,
    output inst_ent_t out_dat
);

    logic      vld_q;
    inst_ent_t ent_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= 1'b0;
            ent_q <= '0;
        end else begin
            if (flush) begin
                vld_q <= 1'b0;
            end else if (in_vld) begin
                vld_q <= 1'b1;
                ent_q <= in_dat;
            end else if (vld_q && out_rdy) begin
                vld_q <= 1'b0;
            end
        end
    end

    assign out_vld = vld_q;
    assign out_dat = ent_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC, one outstanding imem request, trap > branch > +4.
// Latency: imem_ack in cycle N -> inst_valid at N+1; redirect at N -> new imem_addr at N+1 (or ack+1).
// Backpressure: buffer full and decode not ready -> request withdrawn (HOLD) until the transfer.
//
// Ports: clk, rst (async, active-high); redir_valid/redir_addr branch target; trap_valid/trap_addr
//        trap vector; imem_req/imem_addr/imem_ack/imem_rdata memory port; inst_valid/inst_ready/
//        inst_data/inst_pc decode link; fetch_pc trace; misalign_exc misaligned-branch pulse.
// Build option: FETCH_MISALIGN_CHK_EN enables the misaligned branch target check; without it
//        target low bits are cleared and misalign_exc is tied low.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = RESET_VEC_DEF,
    parameter int          XLEN      = XLEN_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redir_valid,
    input  logic [XLEN-1:0] redir_addr,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_addr,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc,
    output logic [XLEN-1:0] fetch_pc,
    output logic            misalign_exc
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] flush_addr_q, flush_addr_d;
    logic            redirect;
    logic            buf_room;
    logic            xfer;
    logic            buf_ld_vld;
    inst_ent_t       buf_in_dat;
    inst_ent_t       buf_out_dat;
    logic            wait_nxt;   // parked in IDLE until a trap redirects

    assign redirect = trap_valid | redir_valid;
    assign xfer     = inst_valid & inst_ready;
    // An ack can only be taken if the buffer is empty or is being drained this cycle.
    assign buf_room = !inst_valid || inst_ready;

`ifdef FETCH_MISALIGN_CHK_EN
    logic bad_tgt;
    logic mis_wait_q;
    logic misalign_q;

    // Only branch targets are checked; a trap vector is trusted.
    assign bad_tgt  = redir_valid && !trap_valid && (redir_addr[1:0] != 2'b00);
    assign wait_nxt = trap_valid ? 1'b0 : (bad_tgt | mis_wait_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mis_wait_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            mis_wait_q <= wait_nxt;
            misalign_q <= bad_tgt;
        end
    end

    assign misalign_exc = misalign_q;
`else
    assign wait_nxt     = 1'b0;
    assign misalign_exc = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            fetch_pc_q   <= RESET_VEC;
            flush_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            flush_addr_q <= flush_addr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        flush_addr_d = flush_addr_q;
        buf_ld_vld   = 1'b0;
        imem_req     = 1'b0;
        imem_addr    = fetch_pc_q;

        unique case (state_q)
            ST_IDLE: begin
                if (!wait_nxt) state_d = ST_REQ;
            end
            ST_REQ: begin
                imem_req = 1'b1;
                if (redirect) begin
                    if (imem_ack) begin
                        // Response of the old path lands now: drop it and restart.
                        state_d = wait_nxt ? ST_IDLE : ST_REQ;
                    end else begin
                        // Keep the old request alive until memory answers it.
                        state_d      = ST_FLUSH;
                        flush_addr_d = fetch_pc_q;
                    end
                end else if (imem_ack && buf_room) begin
                    buf_ld_vld = 1'b1;
                    fetch_pc_d = fetch_pc_q + PC_INC;
                    state_d    = inst_ready ? ST_REQ : ST_HOLD;
                end else if (inst_valid && !inst_ready) begin
                    // Buffer stuck full: withdraw the request; an ack arriving now is not
                    // consumed and the same PC is fetched again after the transfer.
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    state_d = wait_nxt ? ST_IDLE : ST_REQ;
                end else if (xfer) begin
                    state_d = ST_REQ;
                end
            end
            ST_FLUSH: begin
                imem_req  = 1'b1;
                imem_addr = flush_addr_q;
                if (imem_ack) state_d = wait_nxt ? ST_IDLE : ST_REQ;
            end
            default: state_d = ST_IDLE;
        endcase

        if (redirect) begin
            fetch_pc_d = align_pc(trap_valid ? trap_addr : redir_addr);
        end
    end

    assign buf_in_dat = '{pc: fetch_pc_q, dat: imem_rdata};

    fetch_ctrl_buf u_buf (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (buf_ld_vld),
        .in_dat  (buf_in_dat),
        .flush   (redirect),
        .out_vld (inst_valid),
        .out_rdy (inst_ready),
        .out_dat (buf_out_dat)
    );

    assign inst_data = buf_out_dat.dat;
    assign inst_pc   = buf_out_dat.pc;
    assign fetch_pc  = fetch_pc_q;

endmodule
